// File: rtl/dmem_portb_ctrl_pkg.sv
// Shared widths, opcode and state types for the d_mem port-B host sequencer.
// Opcodes and widths track the d_mem port-B definitions used across the codebase.
package dmem_portb_ctrl_pkg;

   localparam int unsigned DMB_ADDR_W = 8;
   localparam int unsigned DMB_DATA_W = 64;
   localparam int unsigned DMB_LEN_W  = 8;

   typedef enum logic [1:0] {
      DMB_OP_RD   = 2'b00,
      DMB_OP_WR   = 2'b01,
      DMB_OP_BRD  = 2'b10,
      DMB_OP_FILL = 2'b11
   } dmb_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN
   } dmb_state_e;

   function automatic logic op_is_write(input dmb_op_e op);
      return (op == DMB_OP_WR) || (op == DMB_OP_FILL);
   endfunction

   function automatic logic op_is_burst(input dmb_op_e op);
      return (op == DMB_OP_BRD) || (op == DMB_OP_FILL);
   endfunction

endpackage

// File: rtl/dmem_rsp_fifo2.sv
// Two-entry {last,data} response FIFO feeding the host read/ack stream.
// Head entry is presented combinationally and held until popped.
module dmem_rsp_fifo2
   import dmem_portb_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DMB_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              push_last,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              head_last,
   output logic [DATA_W-1:0] head_data,
   output logic [1:0]        count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W:0] mem_q [2];
   logic            wr_ptr_q;
   logic            rd_ptr_q;
   logic [1:0]      count_q;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count_q == 2'd0);
   assign full    = (count_q == 2'd2);
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal only when the head leaves the same cycle.
   assign do_push = push && (!full || do_pop);

   assign {head_last, head_data} = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= {push_last, push_data};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/dmem_portb_ctrl.sv
// Host-side sequencer for d_mem port B: single/burst reads and writes, with
// read data and write acks returned over a valid/ready response stream.
module dmem_portb_ctrl
   import dmem_portb_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = DMB_ADDR_W,
   parameter int unsigned DATA_W = DMB_DATA_W,
   parameter int unsigned LEN_W  = DMB_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              busy,
   output logic [ADDR_W-1:0] addrb,
   output logic [DATA_W-1:0] dinb,
   output logic              web,
   input  logic [DATA_W-1:0] doutb
);

   dmb_state_e        state_q, state_d;
   logic              armed_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [LEN_W-1:0]  remaining_q;
   logic [DATA_W-1:0] wdata_q;
   logic              pend_q;
   logic              pend_last_q;
   logic              pend_ack_q;

   logic              accept;
   logic              issue;
   logic              do_write;
   logic              pop;
   logic              drain_done;
   logic [1:0]        occ;
   logic              fifo_head_last;
   logic [DATA_W-1:0] fifo_head_data;
   logic [1:0]        fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic [DATA_W-1:0] fifo_push_data;

   assign req_ready = (state_q == ST_IDLE) && armed_q;
   assign busy      = (state_q != ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign addrb     = cur_addr_q;
   assign dinb      = wdata_q;
   assign web       = (state_q == ST_WRITE);

   assign rsp_valid = !fifo_empty;
   assign rsp_data  = fifo_empty ? '0 : fifo_head_data;
   assign rsp_last  = !fifo_empty && fifo_head_last;
   assign pop       = rsp_valid && rsp_ready;

   // Occupancy after this cycle's pop: a beat leaving now frees room for a new issue.
   assign occ        = fifo_count - {1'b0, pop} + {1'b0, pend_q};
   assign drain_done = !pend_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

   assign fifo_push      = pend_q && (!fifo_full || pop);
   assign fifo_push_data = pend_ack_q ? '0 : doutb;

   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      do_write = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = op_is_write(dmb_op_e'(req_op)) ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            do_write = 1'b1;
            if (remaining_q == '0) state_d = ST_DRAIN;
         end
         ST_READ: begin
            issue = (occ < 2'd2);
            if (issue && (remaining_q == '0)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         armed_q     <= 1'b0;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         wdata_q     <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         pend_ack_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= 1'b1;
         pend_q      <= issue || (do_write && (remaining_q == '0));
         pend_last_q <= do_write || (remaining_q == '0);
         pend_ack_q  <= do_write;
         if (accept) begin
            cur_addr_q  <= req_addr;
            remaining_q <= op_is_burst(dmb_op_e'(req_op)) ? req_len : '0;
            wdata_q     <= req_wdata;
         end else if (issue || do_write) begin
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            if (remaining_q != '0) remaining_q <= remaining_q - LEN_W'(1);
         end
      end
   end

   dmem_rsp_fifo2 #(
      .DATA_W (DATA_W)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_last (pend_last_q),
      .push_data (fifo_push_data),
      .pop       (pop),
      .head_last (fifo_head_last),
      .head_data (fifo_head_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_dmem_portb_ctrl.sv
// Bench for dmem_portb_ctrl: directed and random host operations against a
// simple d_mem port-B model and an array-based reference of memory contents.
module tb_dmem_portb_ctrl;

   localparam logic [1:0] T_RD   = 2'b00;
   localparam logic [1:0] T_WR   = 2'b01;
   localparam logic [1:0] T_BRD  = 2'b10;
   localparam logic [1:0] T_FILL = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_mem;
   logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, busy, web;
   logic [1:0]  req_op;
   logic [7:0]  req_addr, req_len, addrb;
   logic [63:0] req_wdata, rsp_data, dinb, doutb;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [63:0] ref_mem [256];
   logic [63:0] dmem    [256];
   logic [63:0] exp_data[$], got_data[$], exp_wd[$], got_wd[$];
   logic        exp_last[$], got_last[$];
   logic [7:0]  exp_wa[$], got_wa[$];
   int          got_cyc[$], got_wc[$];

   always #5 clk = ~clk;

   dmem_portb_ctrl #(
      .ADDR_W (8),
      .DATA_W (64),
      .LEN_W  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .busy      (busy),
      .addrb     (addrb),
      .dinb      (dinb),
      .web       (web),
      .doutb     (doutb)
   );

   function automatic logic [63:0] seed_val(input int i);
      return {32'(i) ^ 32'hA5A5_0000, 32'(i * 7 + 3)};
   endfunction

   // d_mem port B: synchronous, write-first, one-cycle read latency
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) dmem[i] <= seed_val(i);
      end else if (web) begin
         dmem[addrb] <= dinb;
         doutb       <= dinb;
      end else begin
         doutb <= dmem[addrb];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic        stall;
      logic [63:0] hold_d;
      logic        hold_l;
      if (rsp_valid && rsp_ready) begin
         got_data.push_back(rsp_data);
         got_last.push_back(rsp_last);
         got_cyc.push_back(cyc);
      end
      if (web) begin
         got_wa.push_back(addrb);
         got_wd.push_back(dinb);
         got_wc.push_back(cyc);
      end
      stall  = rsp_valid && !rsp_ready;
      hold_d = rsp_data;
      hold_l = rsp_last;
      @(posedge clk);
      #1;
      cyc++;
      if (stall) begin
         chk("stall_valid", 64'(rsp_valid), 64'd1);
         chk("stall_data", rsp_data, hold_d);
         chk("stall_last", 64'(rsp_last), 64'(hold_l));
      end
   endtask

   task automatic clear_logs();
      exp_data.delete(); exp_last.delete(); exp_wa.delete(); exp_wd.delete();
      got_data.delete(); got_last.delete(); got_wa.delete(); got_wd.delete();
      got_cyc.delete(); got_wc.delete();
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 50 && req_ready !== 1'b1; k++) step();
      chk("req_ready_idle", 64'(req_ready), 64'd1);
   endtask

   // mode: 0 = rsp_ready held high, 1 = random, 2 = pattern 1,0,0
   task automatic run_op(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] len,
                         input logic [63:0] wd, input int mode, input bit inject);
      int         n_words, acc, first_v;
      bit         done, is_wr;
      logic [7:0] a;
      int         pre;
      clear_logs();
      is_wr   = (op == T_WR) || (op == T_FILL);
      n_words = ((op == T_BRD) || (op == T_FILL)) ? int'(len) + 1 : 1;
      for (int i = 0; i < n_words; i++) begin
         a = 8'((int'(addr) + i) % 256);
         if (is_wr) begin
            ref_mem[a] = wd;
            exp_wa.push_back(a);
            exp_wd.push_back(wd);
         end else begin
            exp_data.push_back(ref_mem[a]);
            exp_last.push_back(i == n_words - 1);
         end
      end
      if (is_wr) begin
         exp_data.push_back(64'd0);
         exp_last.push_back(1'b1);
      end

      wait_ready();
      req_valid = 1'b1; req_op = op; req_addr = addr; req_len = len; req_wdata = wd;
      rsp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      req_op = 2'($urandom); req_addr = 8'($urandom); req_len = 8'($urandom);
      req_wdata = {$urandom, $urandom};
      acc = cyc;
      first_v = -1;
      chk("busy_after_accept", 64'(busy), 64'd1);

      done = 1'b0;
      for (int it = 0; it < 1200 && !done; it++) begin
         case (mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = (it % 3 == 0);
         endcase
         if (inject && it == 2) begin
            req_valid = 1'b1;
            chk("req_ready_while_busy", 64'(req_ready), 64'd0);
            chk("busy_mid_op", 64'(busy), 64'd1);
         end
         pre = got_data.size();
         step();
         req_valid = 1'b0;
         if (first_v < 0 && rsp_valid) first_v = cyc;
         if (got_data.size() > pre && got_last[$] === 1'b1) begin
            done = 1'b1;
            chk("ready_after_last", 64'(req_ready), 64'd1);
            chk("idle_after_last", 64'(busy), 64'd0);
         end
      end
      if (!done) chk("op_timeout", 64'd0, 64'd1);
      rsp_ready = 1'b1;
      step();
      step();
      chk("no_extra_valid", 64'(rsp_valid), 64'd0);

      chk("first_beat_latency", 64'(first_v - acc), is_wr ? 64'(n_words + 1) : 64'd2);
      chk("beat_count", 64'(got_data.size()), 64'(exp_data.size()));
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
         chk("beat_data", got_data[i], exp_data[i]);
         chk("beat_last", 64'(got_last[i]), 64'(exp_last[i]));
      end
      chk("write_count", 64'(got_wa.size()), 64'(exp_wa.size()));
      for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
         chk("write_addr", 64'(got_wa[i]), 64'(exp_wa[i]));
         chk("write_data", got_wd[i], exp_wd[i]);
      end
      if (mode == 0 && !is_wr && n_words > 1 && got_cyc.size() == n_words)
         chk("burst_gap", 64'(got_cyc[n_words-1] - got_cyc[0]), 64'(n_words - 1));
      if (is_wr && n_words > 1 && got_wc.size() == n_words)
         chk("write_gap", 64'(got_wc[n_words-1] - got_wc[0]), 64'(n_words - 1));
   endtask

   initial begin
      logic [1:0]  op;
      logic [7:0]  len;
      logic [63:0] fill_v;

      rst = 1'b1; init_mem = 1'b0;
      req_valid = 1'b0; req_op = '0; req_addr = '0; req_len = '0; req_wdata = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i);
      #1;
      chk("rst_web", 64'(web), 64'd0);
      chk("rst_addrb", 64'(addrb), 64'd0);
      chk("rst_dinb", dinb, 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_last", 64'(rsp_last), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      init_mem = 1'b1;
      @(posedge clk);
      #1;
      init_mem = 1'b0;
      rst = 1'b0;
      #1;
      chk("req_ready_before_clk", 64'(req_ready), 64'd0);
      step();
      chk("req_ready_after_clk", 64'(req_ready), 64'd1);

      run_op(T_WR,   8'h10, 8'h00, 64'hDEAD_BEEF, 0, 1'b0);
      run_op(T_RD,   8'h10, 8'h00, 64'h0,         0, 1'b0);
      run_op(T_FILL, 8'h20, 8'h03, 64'h5A,        0, 1'b0);
      run_op(T_BRD,  8'h20, 8'h03, 64'h0,         0, 1'b0);
      run_op(T_BRD,  8'hFE, 8'h03, 64'h0,         2, 1'b0);
      run_op(T_BRD,  8'h30, 8'h07, 64'h0,         1, 1'b1);
      run_op(T_FILL, 8'h60, 8'h07, 64'h1234_5678, 2, 1'b1);

      // reset in the middle of a 16-word fill, while word 5 is on the port
      clear_logs();
      fill_v = 64'hF00D_CAFE_0000_0001;
      wait_ready();
      req_valid = 1'b1; req_op = T_FILL; req_addr = 8'h40; req_len = 8'd15; req_wdata = fill_v;
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("pre_rst_web", 64'(web), 64'd1);
      chk("pre_rst_addrb", 64'(addrb), 64'h45);
      rst = 1'b1;
      #1;
      chk("async_rst_web", 64'(web), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("async_rst_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rel_req_ready_low", 64'(req_ready), 64'd0);
      step();
      chk("rel_req_ready_high", 64'(req_ready), 64'd1);
      chk("rel_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_partial_writes", 64'(got_wa.size()), 64'd5);
      for (int i = 0; i < 5; i++) ref_mem[8'h40 + i] = fill_v;
      run_op(T_RD,  8'h44, 8'h00, 64'h0, 0, 1'b0);
      run_op(T_RD,  8'h45, 8'h00, 64'h0, 0, 1'b0);
      run_op(T_BRD, 8'h3E, 8'h09, 64'h0, 1, 1'b0);

      for (int t = 0; t < 24; t++) begin
         op  = 2'($urandom_range(0, 3));
         len = 8'($urandom_range(0, 12));
         run_op(op, 8'($urandom), len, {$urandom, $urandom}, int'($urandom_range(0, 2)),
                ((op == T_BRD) || (op == T_FILL)) && (len >= 8'd4));
      end

      run_op(T_FILL, 8'h80, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0, 0, 1'b0);
      run_op(T_BRD,  8'h80, 8'hFF, 64'h0,                   0, 1'b0);
      run_op(T_BRD,  8'hF0, 8'h20, 64'h0,                   1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
